lcd_reader: RTL and testbench



---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_bus_phase.sv | 108 ++++++++++
 rtl/lcd_reader.sv | 172 +++++++++++++++++
 tb/tb_lcd_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 read-side engine.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_POLL,
        ST_RD_DATA,
        ST_DONE
    } lcd_rd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } lcd_phase_t;

    localparam logic [7:0]  CMD_SET_DDRAM  = 8'h80;
    localparam int unsigned BF_BIT         = 7;

    localparam int unsigned T_AS_DEF       = 8;
    localparam int unsigned T_PW_DEF       = 25;
    localparam int unsigned T_HOLD_DEF     = 30;
    localparam int unsigned POLL_LIMIT_DEF = 2500;

endpackage

// File: rtl/lcd_bus_phase.sv
// One LCD bus phase: SETUP (E low) -> PULSE (E high) -> HOLD (E low).
// Pin controls are captured on start and otherwise held, so they only move at SETUP entry.
module lcd_bus_phase
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS   = T_AS_DEF,
    parameter int unsigned T_PW   = T_PW_DEF,
    parameter int unsigned T_HOLD = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic       oe_in,
    input  logic [7:0] data_out_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_data_oe,
    output logic [7:0] lcd_data_out,
    output logic       sample_c,
    output logic       phase_done_c
);

    localparam int unsigned T_MAX = (T_AS > T_PW) ? ((T_AS > T_HOLD) ? T_AS : T_HOLD)
                                                  : ((T_PW > T_HOLD) ? T_PW : T_HOLD);
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    lcd_phase_t    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_d, rw_d, e_d, oe_d;
    logic [7:0]    data_d;

    // Next phase, down-counter and pin values; strobes fire on the last cycle of PULSE/HOLD
    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        rs_d         = lcd_rs;
        rw_d         = lcd_rw;
        e_d          = lcd_e;
        oe_d         = lcd_data_oe;
        data_d       = lcd_data_out;
        sample_c     = (phase_q == PH_PULSE) && (cnt_q == '0);
        phase_done_c = (phase_q == PH_HOLD) && (cnt_q == '0);
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = CW'(T_AS - 1);
            e_d     = 1'b0;
            rs_d    = rs_in;
            rw_d    = rw_in;
            oe_d    = oe_in;
            data_d  = data_out_in;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_PULSE;
                        cnt_d   = CW'(T_PW - 1);
                        e_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PH_PULSE: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_HOLD;
                        cnt_d   = CW'(T_HOLD - 1);
                        e_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_IDLE;
                        oe_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase state and registered pin outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_IDLE;
            cnt_q        <= '0;
            lcd_rs       <= 1'b0;
            lcd_rw       <= 1'b1;
            lcd_e        <= 1'b0;
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            lcd_rs       <= rs_d;
            lcd_rw       <= rw_d;
            lcd_e        <= e_d;
            lcd_data_oe  <= oe_d;
            lcd_data_out <= data_d;
        end
    end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-side engine: status read, or set-DDRAM-address / poll BF / read byte.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS       = T_AS_DEF,
    parameter int unsigned T_PW       = T_PW_DEF,
    parameter int unsigned T_HOLD     = T_HOLD_DEF,
    parameter int unsigned POLL_LIMIT = POLL_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       op,
    input  logic [6:0] addr,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] ac,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

    lcd_rd_state_t  state_q, state_d;
    logic           op_q, op_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic           busy_d, done_d, timeout_d, bf_d;
    logic [7:0]     rd_data_d;
    logic [6:0]     ac_d;

    logic           ph_start_c, ph_rs_c, ph_rw_c, ph_oe_c;
    logic [7:0]     ph_data_c;
    logic           sample_c, phase_done_c;

    lcd_bus_phase #(
        .T_AS   (T_AS),
        .T_PW   (T_PW),
        .T_HOLD (T_HOLD)
    ) u_phase (
        .clk          (clk),
        .reset        (reset),
        .start        (ph_start_c),
        .rs_in        (ph_rs_c),
        .rw_in        (ph_rw_c),
        .oe_in        (ph_oe_c),
        .data_out_in  (ph_data_c),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_data_oe  (lcd_data_oe),
        .lcd_data_out (lcd_data_out),
        .sample_c     (sample_c),
        .phase_done_c (phase_done_c)
    );

    // Transaction sequencing; a new phase is launched on the same edge the previous one ends
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        poll_d     = poll_q;
        busy_d     = busy;
        done_d     = 1'b0;
        timeout_d  = timeout;
        rd_data_d  = rd_data;
        bf_d       = bf;
        ac_d       = ac;
        ph_start_c = 1'b0;
        ph_rs_c    = 1'b0;
        ph_rw_c    = 1'b1;
        ph_oe_c    = 1'b0;
        ph_data_c  = 8'h00;

        if (sample_c && (state_q == ST_POLL)) begin
            bf_d = lcd_data_in[BF_BIT];
            ac_d = lcd_data_in[6:0];
        end
        if (sample_c && (state_q == ST_RD_DATA)) begin
            rd_data_d = lcd_data_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    busy_d     = 1'b1;
                    timeout_d  = 1'b0;
                    op_d       = op;
                    poll_d     = '0;
                    ph_start_c = 1'b1;
                    if (op) begin
                        state_d   = ST_WR_ADDR;
                        ph_rw_c   = 1'b0;
                        ph_oe_c   = 1'b1;
                        ph_data_c = CMD_SET_DDRAM | {1'b0, addr};
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (phase_done_c) begin
                    state_d    = ST_POLL;
                    ph_start_c = 1'b1;
                end
            end
            ST_POLL: begin
                if (phase_done_c) begin
                    if (!op_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (!bf) begin
                        state_d    = ST_RD_DATA;
                        ph_start_c = 1'b1;
                        ph_rs_c    = 1'b1;
                    end else begin
                        poll_d = poll_q + PCW'(1);
                        if (poll_q + PCW'(1) == PCW'(POLL_LIMIT)) begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            ph_start_c = 1'b1;
                        end
                    end
                end
            end
            ST_RD_DATA: begin
                if (phase_done_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            poll_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            rd_data <= 8'h00;
            bf      <= 1'b0;
            ac      <= 7'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            poll_q  <= poll_d;
            busy    <= busy_d;
            done    <= done_d;
            timeout <= timeout_d;
            rd_data <= rd_data_d;
            bf      <= bf_d;
            ac      <= ac_d;
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader with a small behavioural LCD model.
module tb_lcd_reader;

    localparam int unsigned T_AS   = 8;
    localparam int unsigned T_PW   = 25;
    localparam int unsigned T_HOLD = 30;
    localparam int unsigned P      = T_AS + T_PW + T_HOLD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       op = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       busy, done, timeout, bf;
    logic [7:0] rd_data, lcd_data_out;
    logic [6:0] ac;
    logic       lcd_data_oe, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data_in = 8'h00;

    lcd_reader #(
        .T_AS       (T_AS),
        .T_PW       (T_PW),
        .T_HOLD     (T_HOLD),
        .POLL_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .rd_data      (rd_data),
        .bf           (bf),
        .ac           (ac),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       to;
        logic [7:0] rd;
        logic       b;
        logic [6:0] a;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    // LCD model: presents read data on E rise, records writes
    logic       status_only = 1'b1;
    logic [7:0] cfg_status = 8'h00;
    logic [7:0] cfg_ddram = 8'h00;
    int         cfg_busy_polls = 0;
    int         wr_count = 0, poll_count = 0, rd_count = 0, polls_since_wr = 0;
    logic [7:0] last_wr = 8'h00;
    logic       last_wr_oe = 1'b0;

    always @(posedge lcd_e) begin
        if (!lcd_rw) begin
            wr_count++;
            last_wr        = lcd_data_out;
            last_wr_oe     = lcd_data_oe;
            polls_since_wr = 0;
        end else if (!lcd_rs) begin
            poll_count++;
            if (status_only) begin
                lcd_data_in = cfg_status;
            end else begin
                lcd_data_in = {(polls_since_wr < cfg_busy_polls), 7'h40};
                polls_since_wr++;
            end
        end else begin
            rd_count++;
            lcd_data_in = cfg_ddram;
        end
    end

    // Monitor: scoreboard pops on done, bus timing invariants every cycle
    int          done_count = 0;
    int          e_run = 0;
    int          since_fall = 1000;
    int          ctrl_age = 1000;
    logic [10:0] prev_ctrl = 11'h0;
    logic        chk_busy_next = 1'b0;

    always @(negedge clk) begin
        logic [10:0] cur;
        exp_t        e;
        cur = {lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out};
        if (reset) begin
            e_run         = 0;
            since_fall    = 1000;
            ctrl_age      = 1000;
            chk_busy_next = 1'b0;
        end else begin
            chk("oe_rw_exclusive", 32'(lcd_data_oe && lcd_rw), 32'd0);
            if (chk_busy_next) chk("busy_after_done", 32'(busy), 32'd0);
            chk_busy_next = done;
            if (ctrl_age < 1000) ctrl_age++;
            if (!lcd_e && e_run == 0 && since_fall < 1000) since_fall++;
            if (cur != prev_ctrl) begin
                chk("ctrl_change_after_hold", 32'(since_fall >= T_HOLD), 32'd1);
                ctrl_age = 0;
            end
            if (lcd_e && e_run == 0) chk("setup_before_e", 32'(ctrl_age >= T_AS), 32'd1);
            if (lcd_e) begin
                e_run++;
            end else if (e_run != 0) begin
                chk("e_pulse_width", 32'(e_run), 32'(T_PW));
                e_run      = 0;
                since_fall = 0;
            end
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.c));
                    chk("timeout", 32'(timeout), 32'(e.to));
                    chk("rd_data", 32'(rd_data), 32'(e.rd));
                    chk("bf", 32'(bf), 32'(e.b));
                    chk("ac", 32'(ac), 32'(e.a));
                end
            end
        end
        prev_ctrl = cur;
    end

    task automatic start_req(input logic o, input logic [6:0] a, output int acc);
        @(negedge clk);
        req  = 1'b1;
        op   = o;
        addr = a;
        acc  = cyc;
        @(negedge clk);
        req  = 1'b0;
    endtask

    task automatic expect_done(input int c, input logic to, input logic [7:0] rd,
                               input logic b, input logic [6:0] a);
        exp_t e;
        e.c  = c;
        e.to = to;
        e.rd = rd;
        e.b  = b;
        e.a  = a;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget, input logic rw_watch);
        int n = 0;
        int v = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            if (rw_watch && busy && !lcd_rw) v++;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        if (rw_watch) chk("rw_high_throughout", 32'(v), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, p0, w0, r0, d0, n;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_timeout", 32'({done, timeout}), 32'd0);
        chk("rst_rd_bf_ac", 32'({rd_data, bf, ac}), 32'd0);
        chk("rst_pins", 32'({lcd_e, lcd_rw, lcd_rs, lcd_data_oe}), 32'b0100);
        chk("rst_data_out", 32'(lcd_data_out), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Status read, BF=0, AC=0x25
        status_only = 1'b1;
        cfg_status  = 8'h25;
        p0 = poll_count;
        start_req(1'b0, 7'h00, a);
        expect_done(a + int'(P) + 1, 1'b0, 8'h00, 1'b0, 7'h25);
        drain(200, 1'b1);
        chk("status_polls", 32'(poll_count - p0), 32'd1);

        // Data read at 0x40, three busy polls then ready, byte 0x41
        status_only    = 1'b0;
        cfg_busy_polls = 3;
        cfg_ddram      = 8'h41;
        p0 = poll_count; w0 = wr_count; r0 = rd_count;
        start_req(1'b1, 7'h40, a);
        expect_done(a + 6 * int'(P) + 1, 1'b0, 8'h41, 1'b0, 7'h40);
        drain(600, 1'b0);
        chk("addr_cmd", 32'(last_wr), 32'hC0);
        chk("addr_cmd_oe", 32'(last_wr_oe), 32'd1);
        chk("data_writes", 32'(wr_count - w0), 32'd1);
        chk("data_polls", 32'(poll_count - p0), 32'd4);
        chk("data_reads", 32'(rd_count - r0), 32'd1);

        // BF stuck high: timeout after the poll limit, no data phase
        cfg_busy_polls = 100;
        cfg_ddram      = 8'h99;
        p0 = poll_count; r0 = rd_count;
        start_req(1'b1, 7'h05, a);
        expect_done(a + 5 * int'(P) + 1, 1'b1, 8'h41, 1'b1, 7'h40);
        drain(600, 1'b0);
        chk("timeout_cmd", 32'(last_wr), 32'h85);
        chk("timeout_polls", 32'(poll_count - p0), 32'd4);
        chk("timeout_reads", 32'(rd_count - r0), 32'd0);

        // Status read after timeout: timeout clears, rd_data kept
        status_only = 1'b1;
        cfg_status  = 8'hFF;
        start_req(1'b0, 7'h00, a);
        expect_done(a + int'(P) + 1, 1'b0, 8'h41, 1'b1, 7'h7F);
        drain(200, 1'b1);

        // Reset on the 10th cycle of the address-write E pulse
        status_only    = 1'b0;
        cfg_busy_polls = 0;
        start_req(1'b1, 7'h12, a);
        n = 0;
        while (!lcd_e && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_e_rise_seen", 32'(lcd_e), 32'd1);
        repeat (9) @(posedge clk);
        #2;
        chk("pre_reset_e_oe", 32'({lcd_e, lcd_data_oe}), 32'b11);
        reset = 1'b1;
        #1;
        chk("mid_reset_e", 32'(lcd_e), 32'd0);
        chk("mid_reset_oe", 32'(lcd_data_oe), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_rw", 32'(lcd_rw), 32'd1);
        chk("mid_reset_results", 32'({rd_data, bf, ac}), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        status_only = 1'b1;
        cfg_status  = 8'h33;
        start_req(1'b0, 7'h00, a);
        expect_done(a + int'(P) + 1, 1'b0, 8'h00, 1'b0, 7'h33);
        drain(200, 1'b1);

        // req pulses while busy are ignored
        cfg_status = 8'h0A;
        d0 = done_count;
        start_req(1'b0, 7'h00, a);
        expect_done(a + int'(P) + 1, 1'b0, 8'h00, 1'b0, 7'h0A);
        repeat (10) @(negedge clk);
        req = 1'b1; op = 1'b1; addr = 7'h22;
        @(negedge clk);
        req = 1'b0;
        repeat (20) @(negedge clk);
        req = 1'b1; op = 1'b0;
        @(negedge clk);
        req = 1'b0;
        drain(200, 1'b1);
        repeat (150) @(negedge clk);
        chk("ignored_req_dones", 32'(done_count - d0), 32'd1);
        chk("idle_after_ignored", 32'(busy), 32'd0);

        // Back-to-back: req held high, second accept in the IDLE cycle after DONE
        cfg_status = 8'h15;
        d0 = done_count;
        @(negedge clk);
        req = 1'b1; op = 1'b0; addr = 7'h00;
        a = cyc;
        expect_done(a + int'(P) + 1, 1'b0, 8'h00, 1'b0, 7'h15);
        expect_done(a + 2 * int'(P) + 3, 1'b0, 8'h00, 1'b0, 7'h15);
        repeat (100) @(negedge clk);
        req = 1'b0;
        drain(300, 1'b1);
        repeat (150) @(negedge clk);
        chk("back_to_back_dones", 32'(done_count - d0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
